// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI burst/response types and FSM state encodings for the RAM slave.
package axi_common;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// Full AXI4 channel bundle; the RAM slave connects through the slave modport.
interface axi_channel #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);
  import axi_common::*;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  burst_t                aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic                  aw_user;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic                  w_user;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_WIDTH-1:0]   b_id;
  resp_t                 b_resp;
  logic                  b_user;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  burst_t                ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic                  ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  resp_t                 r_resp;
  logic                  r_last;
  logic                  r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

endinterface

// File: rtl/axi_ram_slave_addr_gen.sv
// Combinational AXI next-beat address and burst-legality check, shared by read and write paths.
module axi_addr_gen
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);
  localparam int BYTE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ONE << size;
    size_mask = step - ONE;
    wrap_mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    illegal   = (size > 3'(BYTE_LOG2)) || (burst == BURST_RSVD) ||
                ((burst == BURST_WRAP) && !wrap_len_ok(len));
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      // Stay inside the (len+1)<<size window, folding back to its base.
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:     next_addr = (addr & ~size_mask) + step;
    endcase
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: independent write and read FSMs over a byte-lane memory.
module axi_ram_slave
  import axi_common::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic       clk,
  input  logic       rstn,
  axi_channel.slave  slave
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_LOG2  = $clog2(STRB_WIDTH);
  localparam int MEM_WORDS  = 1 << MEM_WORDS_LOG2;

  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_addr_nxt;
  logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]            w_size_q, w_size_d;
  burst_t                w_burst_q, w_burst_d;
  resp_t                 b_resp_q, b_resp_d;
  logic                  w_illegal, mem_we;

  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_addr_nxt;
  logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]            r_size_q, r_size_d;
  burst_t                r_burst_q, r_burst_d;
  resp_t                 r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_illegal;

  logic [MEM_WORDS_LOG2-1:0] w_idx, r_idx;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      unused_sideband;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_w_addr_gen (
    .addr(w_addr_q), .size(w_size_q), .len(w_len_q), .burst(w_burst_q),
    .next_addr(w_addr_nxt), .illegal(w_illegal)
  );

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_r_addr_gen (
    .addr(r_addr_q), .size(r_size_q), .len(r_len_q), .burst(r_burst_q),
    .next_addr(r_addr_nxt), .illegal(r_illegal)
  );

  // Upper address bits are dropped, so the memory aliases across the address space.
  assign w_idx = w_addr_q[BYTE_LOG2 +: MEM_WORDS_LOG2];
  assign r_idx = r_addr_q[BYTE_LOG2 +: MEM_WORDS_LOG2];

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    always_ff @(posedge clk) begin
      if (mem_we && slave.w_strb[gi]) lane_mem[w_idx] <= slave.w_data[gi*8 +: 8];
    end
    assign rd_word[gi*8 +: 8] = lane_mem[r_idx];
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    slave.aw_ready = 1'b0;
    slave.w_ready  = 1'b0;
    slave.b_valid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        slave.aw_ready = rstn;
        if (slave.aw_valid) begin
          w_id_d    = slave.aw_id;
          w_addr_d  = slave.aw_addr;
          w_len_d   = slave.aw_len;
          w_size_d  = slave.aw_size;
          w_burst_d = slave.aw_burst;
          w_beat_d  = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        slave.w_ready = 1'b1;
        if (slave.w_valid) begin
          mem_we   = !w_illegal;
          w_addr_d = w_addr_nxt;
          w_beat_d = w_beat_q + 8'd1;
          if (w_beat_q == w_len_q) begin
            w_state_d = W_RESP;
            b_resp_d  = (w_illegal || !slave.w_last) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        slave.b_valid = 1'b1;
        if (slave.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    slave.ar_ready = 1'b0;
    slave.r_valid  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        slave.ar_ready = rstn;
        if (slave.ar_valid) begin
          r_id_d    = slave.ar_id;
          r_addr_d  = slave.ar_addr;
          r_len_d   = slave.ar_len;
          r_size_d  = slave.ar_size;
          r_burst_d = slave.ar_burst;
          r_beat_d  = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_data_d  = r_illegal ? '0 : rd_word;
        r_resp_d  = r_illegal ? RESP_SLVERR : RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        slave.r_valid = 1'b1;
        if (slave.r_ready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_nxt;
            r_beat_d  = r_beat_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= BURST_FIXED;
      w_beat_q  <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      b_resp_q  <= b_resp_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= BURST_FIXED;
      r_beat_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

  assign slave.b_id   = w_id_q;
  assign slave.b_resp = b_resp_q;
  assign slave.b_user = 1'b0;
  assign slave.r_id   = r_id_q;
  assign slave.r_data = r_data_q;
  assign slave.r_resp = r_resp_q;
  assign slave.r_user = 1'b0;
  assign slave.r_last = (r_state_q == R_DATA) && (r_beat_q == r_len_q);

  // Lock, cache, prot, qos, region and user carry no meaning for this memory.
  assign unused_sideband = ^{slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos,
                             slave.aw_region, slave.aw_user, slave.w_user,
                             slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos,
                             slave.ar_region, slave.ar_user};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: expected B/R beats are queued at issue and checked on handshake.
`timescale 1ns/1ps
module tb_axi_ram_slave;
  import axi_common::*;

  localparam int IDW = 8;
  localparam int AW  = 48;
  localparam int DW  = 64;
  localparam int MWL = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_ram_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS_LOG2(MWL)) dut (
    .clk(clk), .rstn(rstn), .slave(bus)
  );

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        chk_data;
  } r_exp_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      r_exp_q[$];
  b_exp_t      b_exp_q[$];
  logic [63:0] ref_mem [1024];
  bit          ref_known [1024];
  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];
  int          n_checks = 0;
  int          n_pass = 0;
  int          r_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [47:0] beat_addr(input logic [47:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
    longint nb, total, base, s;
    nb = longint'(1) << size;
    s  = longint'(start);
    case (burst)
      2'b00: return start;
      2'b10: begin
        total = nb * (longint'(len) + 1);
        base  = (s / total) * total;
        return 48'(base + ((s - base + longint'(i) * nb) % total));
      end
      default: return (i == 0) ? start : 48'((s / nb) * nb + longint'(i) * nb);
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    if (size > 3'd3) return 1'b0;
    if (burst == 2'b11) return 1'b0;
    if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int word_idx(input logic [47:0] a);
    return int'((a >> 3) & 48'h3FF);
  endfunction

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return bus.aw_ready;
      1:       return bus.w_ready;
      default: return bus.ar_ready;
    endcase
  endfunction

  task automatic hs_wait(input int ch, input string tag);
    int   n;
    logic seen;
    n = 0;
    do begin
      @(negedge clk);
      seen = rdy(ch);
      @(posedge clk);
      #1;
      n++;
    end while (!seen && n < 200);
    if (!seen) check_eq(tag, seen, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, r_exp_q.size() + b_exp_q.size(), 0);
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit drop_last);
    bit     ok;
    b_exp_t be;
    int     wi;
    ok = is_legal(size, len, burst);
    if (ok) begin
      for (int i = 0; i <= int'(len); i++) begin
        wi = word_idx(beat_addr(addr, size, len, burst, i));
        for (int b = 0; b < 8; b++)
          if (sbuf[i][b]) ref_mem[wi][b*8 +: 8] = wbuf[i][b*8 +: 8];
        if (sbuf[i] == 8'hFF) ref_known[wi] = 1'b1;
      end
    end
    be.id   = id;
    be.resp = (ok && !drop_last) ? 2'b00 : 2'b10;
    b_exp_q.push_back(be);
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size;
    bus.aw_burst = burst_t'(burst); bus.aw_valid = 1'b1;
    hs_wait(0, "aw_timeout");
    bus.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.w_data = wbuf[i]; bus.w_strb = sbuf[i];
      bus.w_last = (i == int'(len)) && !drop_last; bus.w_valid = 1'b1;
      hs_wait(1, "w_timeout");
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
    wait_drain("b_drain");
  endtask

  task automatic push_read_exp(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    bit     ok;
    r_exp_t e;
    int     wi;
    ok = is_legal(size, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wi = word_idx(beat_addr(addr, size, len, burst, i));
      e.id = id;
      e.data = ref_mem[wi];
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      e.chk_data = ok && ref_known[wi];
      r_exp_q.push_back(e);
    end
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    push_read_exp(id, addr, len, size, burst);
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size;
    bus.ar_burst = burst_t'(burst); bus.ar_valid = 1'b1;
    hs_wait(2, "ar_timeout");
    bus.ar_valid = 1'b0;
    wait_drain("r_drain");
  endtask

  // R and B monitors: a handshake seen at this negedge completes at the next posedge.
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t bx;
    if (rstn && bus.r_valid && bus.r_ready) begin
      r_seen++;
      if (r_exp_q.size() == 0) begin
        check_eq("r_spurious", bus.r_valid, 1'b0);
      end else begin
        re = r_exp_q.pop_front();
        $display("R beat id=0x%0h data=0x%016h resp=%0d last=%0d", bus.r_id, bus.r_data, bus.r_resp, bus.r_last);
        check_eq("r_id", bus.r_id, re.id);
        check_eq("r_resp", bus.r_resp, re.resp);
        check_eq("r_last", bus.r_last, re.last);
        check_eq("r_user", bus.r_user, 1'b0);
        if (re.chk_data) check_eq("r_data", bus.r_data, re.data);
      end
    end
    if (rstn && bus.b_valid && bus.b_ready) begin
      if (b_exp_q.size() == 0) begin
        check_eq("b_spurious", bus.b_valid, 1'b0);
      end else begin
        bx = b_exp_q.pop_front();
        $display("B resp id=0x%0h resp=%0d", bus.b_id, bus.b_resp);
        check_eq("b_id", bus.b_id, bx.id);
        check_eq("b_resp", bus.b_resp, bx.resp);
        check_eq("b_user", bus.b_user, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_exp_t ce;
    b_exp_t cb;
    int     n;
    int     base_seen;

    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = BURST_INCR;
    bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0;
    bus.aw_user = 1'b0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = 1'b0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = BURST_INCR;
    bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0;
    bus.ar_user = 1'b0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_aw_ready", bus.aw_ready, 1'b0);
    check_eq("rst_ar_ready", bus.ar_ready, 1'b0);
    check_eq("rst_w_ready", bus.w_ready, 1'b0);
    check_eq("rst_b_valid", bus.b_valid, 1'b0);
    check_eq("rst_r_valid", bus.r_valid, 1'b0);
    check_eq("rst_r_last", bus.r_last, 1'b0);
    rstn = 1'b1;
    #1;
    check_eq("rel_aw_ready", bus.aw_ready, 1'b1);
    check_eq("rel_ar_ready", bus.ar_ready, 1'b1);
    check_eq("rel_r_data", bus.r_data, 64'h0);
    check_eq("rel_b_resp", bus.b_resp, 2'b00);
    @(posedge clk);
    #1;

    // Single-beat write then read back
    wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
    axi_write(8'h5A, 48'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    axi_read(8'hA5, 48'h10, 8'd0, 3'd3, 2'b01);

    // Partial strobe over zeroed words
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h0; sbuf[i] = 8'hFF; end
    axi_write(8'h01, 48'h20, 8'd3, 3'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = '1; sbuf[i] = 8'hFF; end
    sbuf[2] = 8'h0F;
    axi_write(8'h02, 48'h20, 8'd3, 3'd3, 2'b01, 1'b0);
    axi_read(8'h03, 48'h20, 8'd3, 3'd3, 2'b01);

    // WRAP burst starting mid-window
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hA0A0_0000_0000_0000 + 64'(i); sbuf[i] = 8'hFF; end
    axi_write(8'h04, 48'h38, 8'd3, 3'd3, 2'b10, 1'b0);
    axi_read(8'h05, 48'h38, 8'd3, 3'd3, 2'b10);
    axi_read(8'h06, 48'h20, 8'd3, 3'd3, 2'b01);

    // Illegal bursts: SLVERR, beats consumed, memory untouched
    axi_read(8'h07, 48'h20, 8'd1, 3'd4, 2'b01);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hBAD0_BAD0_BAD0_BAD0; sbuf[i] = 8'hFF; end
    axi_write(8'h08, 48'h20, 8'd1, 3'd4, 2'b01, 1'b0);
    axi_write(8'h09, 48'h28, 8'd0, 3'd3, 2'b11, 1'b0);
    axi_write(8'h0A, 48'h20, 8'd2, 3'd3, 2'b10, 1'b0);
    axi_read(8'h0B, 48'h28, 8'd0, 3'd3, 2'b11);
    axi_read(8'h0C, 48'h20, 8'd3, 3'd3, 2'b01);

    // Missing w_last on the final beat
    wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hFEDC_BA98_7654_3210; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(8'h0D, 48'h80, 8'd1, 3'd3, 2'b01, 1'b1);
    axi_read(8'h0E, 48'h80, 8'd1, 3'd3, 2'b01);

    // FIXED burst keeps hitting one word
    for (int i = 0; i < 3; i++) begin wbuf[i] = 64'hF1F1_0000_0000_0010 + 64'(i); sbuf[i] = 8'hFF; end
    axi_write(8'h0F, 48'h90, 8'd2, 3'd3, 2'b00, 1'b0);
    axi_read(8'h10, 48'h90, 8'd1, 3'd3, 2'b00);

    // Address aliasing above the memory depth
    wbuf[0] = 64'h5555_AAAA_5555_AAAA; sbuf[0] = 8'hFF;
    axi_write(8'h11, 48'h2008, 8'd0, 3'd3, 2'b01, 1'b0);
    axi_read(8'h12, 48'h08, 8'd0, 3'd3, 2'b01);

    // Write beat colliding with read fetch of the same word
    wbuf[0] = 64'h0DD0_0DD0_0DD0_0DD0; sbuf[0] = 8'hFF;
    axi_write(8'h30, 48'h40, 8'd0, 3'd3, 2'b01, 1'b0);
    ce.id = 8'h32; ce.data = ref_mem[8]; ce.resp = 2'b00; ce.last = 1'b1; ce.chk_data = 1'b1;
    r_exp_q.push_back(ce);
    ref_mem[8] = 64'h4E45_5700_4E45_5700;
    cb.id = 8'h31; cb.resp = 2'b00;
    b_exp_q.push_back(cb);
    bus.aw_id = 8'h31; bus.aw_addr = 48'h40; bus.aw_len = 8'd0; bus.aw_size = 3'd3;
    bus.aw_burst = BURST_INCR; bus.aw_valid = 1'b1;
    hs_wait(0, "aw_timeout");
    bus.aw_valid = 1'b0;
    bus.ar_id = 8'h32; bus.ar_addr = 48'h40; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
    bus.ar_burst = BURST_INCR; bus.ar_valid = 1'b1;
    @(negedge clk);
    check_eq("conc_ar_ready", bus.ar_ready, 1'b1);
    check_eq("conc_w_ready", bus.w_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.ar_valid = 1'b0;
    bus.w_data = 64'h4E45_5700_4E45_5700; bus.w_strb = 8'hFF; bus.w_last = 1'b1; bus.w_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.w_valid = 1'b0;
    bus.w_last = 1'b0;
    wait_drain("conc_drain");
    axi_read(8'h33, 48'h40, 8'd0, 3'd3, 2'b01);

    // Reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) begin wbuf[i] = 64'hC0DE_0000_0000_0100 + 64'(i); sbuf[i] = 8'hFF; end
    axi_write(8'h40, 48'h100, 8'd7, 3'd3, 2'b01, 1'b0);
    base_seen = r_seen;
    push_read_exp(8'h41, 48'h100, 8'd7, 3'd3, 2'b01);
    bus.ar_id = 8'h41; bus.ar_addr = 48'h100; bus.ar_len = 8'd7; bus.ar_size = 3'd3;
    bus.ar_burst = BURST_INCR; bus.ar_valid = 1'b1;
    hs_wait(2, "ar_timeout");
    bus.ar_valid = 1'b0;
    n = 0;
    while (r_seen < base_seen + 2 && n < 100) begin @(posedge clk); #1; n++; end
    bus.r_ready = 1'b0;
    check_eq("two_beats_before_rst", r_seen - base_seen, 2);
    n = 0;
    while (!bus.r_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("beat3_presented", bus.r_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_r_valid", bus.r_valid, 1'b0);
    check_eq("mid_rst_r_last", bus.r_last, 1'b0);
    check_eq("mid_rst_r_data", bus.r_data, 64'h0);
    check_eq("mid_rst_ar_ready", bus.ar_ready, 1'b0);
    r_exp_q.delete();
    bus.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check_eq("post_rst_ar_ready", bus.ar_ready, 1'b1);
    check_eq("post_rst_aw_ready", bus.aw_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check_eq("no_beats_after_rst", bus.r_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    axi_read(8'h42, 48'h100, 8'd3, 3'd3, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Parameter: ID_WIDTH, 8, AXI ID width; SHALL match the connected axi_channel.
REQ-002 Parameter: ADDR_WIDTH, 48, AXI address width; SHALL match the connected axi_channel.
REQ-003 Parameter: DATA_WIDTH, 64, AXI data width; SHALL match the connected axi_channel; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter: MEM_WORDS_LOG2, 10, log2 of memory depth in DATA_WIDTH words.
REQ-005 Port: clk  input  1  sole clock; all state on rising edge.
REQ-006 Port: rstn  input  1  asynchronous, active-low reset.
REQ-007 Port: slave  axi_channel.slave  -  AXI4 responder end; all five channels driven/sampled per slave modport.

Function
REQ-008 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP.
REQ-009 W_IDLE: aw_ready=1; on aw_valid SHALL capture id/addr/len/size/burst and go to W_DATA.
REQ-010 W_DATA: w_ready=1; each w handshake SHALL write bytes with w_strb set at current word, advance address, increment beat count.
REQ-011 Write burst SHALL end when beat count equals captured len, then go to W_RESP; w_last not asserted on exactly that beat -> b_resp SLVERR.
REQ-012 W_RESP: b_valid=1, b_id=captured id, b_user=0; on b_ready go to W_IDLE.
REQ-013 Read FSM states SHALL be R_IDLE, R_FETCH, R_DATA; R_IDLE: ar_ready=1, ar handshake captures as REQ-009, go to R_FETCH.
REQ-014 R_FETCH: one cycle; SHALL register memory word at current address into r_data; go to R_DATA.
REQ-015 R_DATA: r_valid=1, r_id=captured id, r_last=(beat==len), r_user=0; r_data stable until r_ready.
REQ-016 On r handshake: last -> R_IDLE, else advance address -> R_FETCH (throughput one beat per 2 cycles).
REQ-017 Word index SHALL be addr[log2(STRB_WIDTH)+MEM_WORDS_LOG2-1 : log2(STRB_WIDTH)]; upper bits ignored (aliasing).
REQ-018 FIXED: address unchanged; INCR: size-aligned addr + (1<<size); WRAP: increment within boundary (len+1)<<size, wrapping to boundary base.
REQ-019 SLVERR, no memory access, beats still consumed, for: size > log2(STRB_WIDTH); burst=2'b11; WRAP with len not in {1,3,7,15}.
REQ-020 Otherwise resp OKAY; aw_lock/ar_lock treated as normal access (never EXOKAY); cache/prot/qos/region/user ignored.
REQ-021 Read and write FSMs SHALL run independently and concurrently.
REQ-022 Write and R_FETCH to same word in same cycle: fetch SHALL return pre-write data.

Reset
REQ-023 rstn low SHALL force W_IDLE/R_IDLE, b_valid=0, r_valid=0, r_last=0, r_data=0, b_resp/r_resp=OKAY, beat counters 0.
REQ-024 aw_ready, ar_ready, w_ready SHALL be 0 while rstn low; aw_ready/ar_ready=1 first cycle after release.
REQ-025 Reset mid-burst: burst abandoned, no response issued; already-written memory words persist; memory contents never reset.

Structure
REQ-026 burst_t/resp_t and constants BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR SHALL come from axi_common.
REQ-027 Next-address computation SHALL be one combinational sub-module axi_addr_gen (inputs addr, size, len, burst; outputs next addr, illegal flag), instantiated for write and read paths.

Verification
REQ-028 AW addr 0x10 len 0 size 3 INCR, W 0x1122334455667788 strb 0xFF last -> B OKAY id echoed; AR same -> R same data, r_last=1.
REQ-029 INCR len 3 size 3 at 0x20, beat 2 strb 0x0F data all-ones over zeroed memory -> read-back word 0x30 = 0x00000000FFFFFFFF, others all-ones.
REQ-030 WRAP len 3 size 3 addr 0x38 -> beats hit 0x38, 0x20, 0x28, 0x30; read-back order matches.
REQ-031 AR size 4, len 1 on 64-bit bus -> two R beats r_resp SLVERR, r_last on second only; memory unchanged.
REQ-032 Write beat to word 0x40 in same cycle as R_FETCH of 0x40 -> old value returned; subsequent read returns new value.
REQ-033 rstn low during beat 3 of 8-beat read -> r_valid 0 immediately, no further beats; ar_ready=1 cycle after release; new read succeeds.
